// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer
// and synchronous flush; in_ready depends only on held state and reset.
module pipe_stage_reg #(
  parameter int               WIDTH          = 32,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0,
  parameter bit               CLEAR_ON_FLUSH = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_p0, state_nxt;
  logic [WIDTH-1:0] main_p0, main_nxt;
  logic [WIDTH-1:0] skid_p0, skid_nxt;
  logic             in_fire, out_fire;

  assign in_ready  = (state_p0 != FULL) & rst;
  assign out_valid = (state_p0 != EMPTY);
  assign out_data  = main_p0;
  assign occupancy = state_p0;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_nxt = state_p0;
    main_nxt  = main_p0;
    skid_nxt  = skid_p0;
    if (flush) begin
      // Incoming beat is dropped even if in_ready reads 1 this cycle.
      state_nxt = EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_nxt = RESET_VAL;
        skid_nxt = RESET_VAL;
      end
    end else begin
      case (state_p0)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = ONE;
            main_nxt  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (in_fire) begin
            state_nxt = FULL;
            skid_nxt  = in_data;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_nxt = ONE;
            main_nxt  = skid_p0;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Stage boundary: state and payload registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_p0 <= EMPTY;
      main_p0  <= RESET_VAL;
      skid_p0  <= RESET_VAL;
    end else begin
      state_p0 <= state_nxt;
      main_p0  <= main_nxt;
      skid_p0  <= skid_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random soak, all checked
// against a queue-based model of the stage contents.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0]  occupancy;

  logic        flush2, in_valid2, in_ready2, out_valid2, out_ready2, rst2;
  logic [31:0] in_data2, out_data2;
  logic [1:0]  occupancy2;

  pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h0), .CLEAR_ON_FLUSH(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h0), .CLEAR_ON_FLUSH(1'b0)) dut_hold (
    .clk(clk), .rst(rst2), .flush(flush2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .occupancy(occupancy2)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] q[$];
  logic [31:0] main_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of the CLEAR_ON_FLUSH=1 instance, checked against the queue model.
  task automatic cyc(input logic r, input logic f, input logic iv,
                     input logic [31:0] d, input logic ordy);
    logic exp_ir, ifire, ofire;
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    exp_ir = r && (q.size() < 2);
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    ifire = iv && exp_ir;
    ofire = (q.size() > 0) && ordy;
    @(posedge clk);
    if (!r) begin
      q.delete();
      main_val = 32'h0;
    end else if (f) begin
      q.delete();
      main_val = 32'h0;
    end else begin
      if (ofire) begin
        main_val = q[0];
        void'(q.pop_front());
      end
      if (ifire) q.push_back(d);
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("out_data", out_data, (q.size() > 0) ? q[0] : main_val);
    chk("occupancy", 32'(occupancy), 32'(q.size()));
  endtask

  initial begin
    logic r, f, iv, o;
    main_val = 32'h0;
    rst2 = 1'b0; flush2 = 1'b0; in_valid2 = 1'b0; in_data2 = 32'h0; out_ready2 = 1'b0;

    // Reset held two cycles with a valid beat presented.
    cyc(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
    chk("reset_out_data", out_data, 32'h0);
    chk("reset_occ", 32'(occupancy), 32'd0);
    rst2 = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Streaming with downstream always ready.
    cyc(1'b1, 1'b0, 1'b1, 32'h1, 1'b1);
    chk("stream_first", out_data, 32'h1);
    cyc(1'b1, 1'b0, 1'b1, 32'h2, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 32'h3, 1'b1);
    chk("stream_occ_le1", 32'(occupancy <= 2'd1), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Stall fills the skid, then drains in order.
    cyc(1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
    chk("stall_occ", 32'(occupancy), 32'd2);
    chk("stall_head", out_data, 32'hA);
    cyc(1'b1, 1'b0, 1'b1, 32'hF00, 1'b0);
    chk("stall_hold", out_data, 32'hA);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("drain_second", out_data, 32'hB);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Flush while full, with a beat offered in the same cycle.
    cyc(1'b1, 1'b0, 1'b1, 32'h11, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 32'h22, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 32'hC, 1'b0);
    chk("flush_data_cleared", out_data, 32'h0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    // Flush on the holding instance keeps its payload.
    in_valid2 = 1'b1; in_data2 = 32'h55; out_ready2 = 1'b0;
    @(posedge clk); #1;
    chk("hold_push_valid", 32'(out_valid2), 32'd1);
    chk("hold_push_data", out_data2, 32'h55);
    in_valid2 = 1'b0; flush2 = 1'b1;
    @(posedge clk); #1;
    chk("hold_flush_valid", 32'(out_valid2), 32'd0);
    chk("hold_flush_data", out_data2, 32'h55);
    chk("hold_flush_occ", 32'(occupancy2), 32'd0);
    flush2 = 1'b0; in_valid2 = 1'b1; in_data2 = 32'h66; out_ready2 = 1'b1;
    @(posedge clk); #1;
    chk("hold_repush_valid", 32'(out_valid2), 32'd1);
    chk("hold_repush_data", out_data2, 32'h66);
    in_valid2 = 1'b0;

    // Reset while full discards both entries.
    cyc(1'b1, 1'b0, 1'b1, 32'h7, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 32'h8, 1'b0);
    chk("mid_full_occ", 32'(occupancy), 32'd2);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("mid_reset_data", out_data, 32'h0);
    chk("mid_reset_occ", 32'(occupancy), 32'd0);

    // Random soak with rare flushes and resets.
    for (int i = 0; i < 10000; i++) begin
      r  = ($urandom_range(0, 499) != 0);
      f  = ($urandom_range(0, 99) == 0);
      iv = 1'($urandom_range(0, 1));
      o  = 1'($urandom_range(0, 1));
      cyc(r, f, iv, $urandom, o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register with a valid/ready handshake on both sides. It adds a one-entry skid buffer, so in_ready depends only on internal state and never combinationally on out_ready. It also provides a synchronous flush that turns the stage into a bubble. It sits between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), replacing the plain enable-gated 32-bit register where stall and flush control is needed.

Parameters:
WIDTH, 32, payload width in bits (at least 1)
RESET_VAL, {WIDTH{1'b0}}, value loaded into both data registers on reset
CLEAR_ON_FLUSH, 1, 1 = data registers reload RESET_VAL on flush; 0 = data registers hold their contents on flush

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk
flush  input  1  synchronous kill of all stage contents
in_valid  input  1  upstream presents in_data
in_ready  output  1  stage can accept; depends on state only
in_data  input  WIDTH  upstream payload
out_valid  output  1  out_data holds a valid entry
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  WIDTH  head-of-stage payload, driven directly from a register
occupancy  output  2  number of held entries: 0, 1 or 2

Behaviour:
- Handshake events:
  - in_fire = in_valid & in_ready
  - out_fire = out_valid & out_ready
- Storage: main register (drives out_data) and skid register. The state encodes occupancy: EMPTY=0, ONE=1, FULL=2.
- Output decode:
  - out_valid = (state != EMPTY)
  - in_ready = (state != FULL) & rst; in_ready is forced to 0 while rst is low
  - occupancy = state encoding
- Reset (rst=0 at an edge):
  - state <= EMPTY
  - main <= RESET_VAL, skid <= RESET_VAL
  - Takes priority over flush and all handshakes.
  - Reset mid-transfer discards everything held.
- Flush (rst=1, flush=1):
  - state <= EMPTY.
  - in_fire is ignored that cycle: in_data is discarded even though in_ready may read 1.
  - An out_fire in the same cycle counts as consumed by downstream; no special action.
  - If CLEAR_ON_FLUSH=1, main and skid <= RESET_VAL. Otherwise both hold.
- Normal transitions (rst=1, flush=0):
  - EMPTY:
    - in_fire -> ONE, main <= in_data
    - else stay EMPTY
  - ONE:
    - in_fire & out_fire -> ONE, main <= in_data
    - in_fire & !out_fire -> FULL, skid <= in_data
    - !in_fire & out_fire -> EMPTY
    - neither -> hold
  - FULL (in_ready=0):
    - out_fire -> ONE, main <= skid
    - else hold
- Latency: data accepted at edge N appears on out_data with out_valid=1 after edge N (one cycle) when the stage was EMPTY or draining.
- Throughput: one transfer per cycle sustained while out_ready=1.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid do not change, except on flush or reset.
- Ordering: strict FIFO; the skid entry never overtakes main.
- No data is lost or duplicated on any handshake combination.
- Data registers update only on the events listed above; no other writes.
- Width: pure pass-through; no arithmetic on the payload.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with in_valid=1 and in_data=32'hDEADBEEF -> out_valid=0, out_data=0, occupancy=0, in_ready=0 during reset. After rst=1: in_ready=1.
2. Streaming: out_ready=1, push 32'h1, 32'h2, 32'h3 on consecutive cycles -> out_data shows 1, 2, 3 on consecutive cycles, one cycle after each push; occupancy stays at or below 1.
3. Stall and skid: push 32'hA then 32'hB with out_ready=0 -> occupancy=2, in_ready=0, out_data=32'hA held. Raise out_ready -> next two cycles emit A then B; in_ready returns to 1 after the first out_fire.
4. Flush while FULL (CLEAR_ON_FLUSH=1), with 32'hC presented and in_valid=1 in the same cycle -> next cycle occupancy=0, out_valid=0, out_data=0. 32'hC never appears at the output.
5. Flush with CLEAR_ON_FLUSH=0, holding 32'h55 -> out_valid=0 and out_data stays 32'h55. A following push of 32'h66 -> out_data=32'h66 with out_valid=1.
6. Reset mid-transfer: stage FULL with 32'h7 and 32'h8, then rst=0 for one edge -> EMPTY with both registers at 0. Random in_valid/out_ready soak for 10k cycles against a scoreboard -> in-order delivery, no loss, no duplicates.
